product_accumulator: RTL and testbench
======================================

Name: product_accumulator

Overview:
- Downstream stage of the 8x8 sequential multiplier: consumes its 16-bit products Z and sums a frame of them into a wider accumulator.
- Frame length is COUNT products, or fewer when in_last ends the frame early. The frame sum is presented on a valid/ready output handshake.
- Used for dot-product and MAC style flows built on the multiplier.

Parameters:
- IN_W, 16, product width; matches multiplier Z.
- ACC_W, 24, accumulator and out_sum width; must be >= IN_W.
- COUNT, 4, products per full frame; must be >= 1.
- CNT_W, $clog2(COUNT+1), width of the frame product counter.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- clear  in  1  synchronous abort: drop the current frame and any pending result.
- in_valid  in  1  product present on in_data.
- in_ready  out  1  stage can accept a product.
- in_data  in  IN_W  unsigned product.
- in_last  in  1  qualified by in_valid; the accepted product is the last of the frame.
- out_valid  out  1  frame result available.
- out_ready  in  1  consumer accepts the result.
- out_sum  out  ACC_W  frame sum, modulo 2^ACC_W.
- out_count  out  CNT_W  number of products in the frame.
- out_ovf  out  1  frame sum exceeded 2^ACC_W-1 at least once (sticky within the frame).

Behaviour:
- Reset (rst_n=0, asynchronous):
  - state=ACC, acc=0, cnt=0, ovf=0.
  - out_valid=0, out_sum=0, out_count=0, out_ovf=0, in_ready=1.
- States are ACC and DONE.
- in_ready = (state==ACC) && !clear. It is purely a function of registered state and clear; it never depends combinationally on in_valid.
- Accept = in_valid && in_ready:
  - acc <= acc + zero-extended in_data, truncated to ACC_W bits.
  - The carry out of bit ACC_W-1 ORs into ovf.
  - cnt <= cnt+1.
- Frame end: on an accept where cnt+1==COUNT or in_last==1.
  - Go to DONE.
  - out_sum <= new acc, out_count <= cnt+1, out_ovf <= new ovf.
  - out_valid <= 1.
  - Latency: out_valid rises 1 cycle after the final accept.
- in_last on a product before COUNT is reached ends the frame early. in_last on the COUNTth product has no extra effect.
- DONE state:
  - in_ready=0.
  - out_sum, out_count and out_ovf are held stable while out_valid && !out_ready.
  - On out_valid && out_ready: out_valid <= 0, acc/cnt/ovf <= 0, state <= ACC. No input is accepted in that cycle. in_ready rises the next cycle.
- Between frames:
  - out_sum, out_count and out_ovf keep their last values after out_valid drops.
  - They are only meaningful while out_valid=1.
- clear=1 (synchronous, priority over every handshake):
  - acc, cnt and ovf <= 0; out_valid <= 0; state <= ACC.
  - Any product presented that cycle is dropped; in_ready is 0 that cycle.
  - out_sum, out_count and out_ovf are not cleared.
- Reset mid-frame or with a pending result: everything returns to reset values immediately; the partial frame is lost.
- An in_valid held with unchanged in_data across cycles is a new product each cycle in_ready=1. The upstream side owns pulse framing.
- Arithmetic: unsigned only; wrap-around is modulo 2^ACC_W, with out_ovf flagging the wrap.

Test Plan:
- Full frame: products 21,49,6,10 back-to-back, out_ready=1 -> out_valid 1 cycle after 4th accept; out_sum=86, out_count=4, out_ovf=0. in_ready high again 2 cycles after 4th accept.
- Backpressure: frame 7,7,7,7 with out_ready=0 for 5 cycles -> out_sum=28 held stable and in_ready=0 throughout. A product driven meanwhile is not consumed. Single-cycle handshake when out_ready rises.
- Early end: 15, then 25 with in_last=1 -> out_sum=40, out_count=2; the next frame starts from acc=0.
- Overflow with ACC_W=17: four products of 65535 -> out_sum=131068, out_ovf=1. The following frame 1,1,1,1 gives out_sum=4, out_ovf=0.
- Reset mid-frame: accept 40,64, pulse rst_n low asynchronously between clock edges -> outputs zero immediately. Then 48,40,10,15 -> out_sum=113.
- Clear: assert clear in DONE (out_ready=0) -> out_valid drops next cycle; a product presented with clear is not counted. Next frame 2,3,4,5 -> out_sum=14.

Source files
------------

// File: rtl/product_accumulator.sv
// ---------------------------------------------------------------------------
// product_accumulator
//   Sums a frame of unsigned products (e.g. from the 8x8 sequential
//   multiplier) into an ACC_W-bit accumulator and presents the frame result
//   on a valid/ready output.
//
//   Handshakes (both sides): a transfer happens on a rising clk edge where
//   valid && ready are both 1. valid never waits on ready. in_ready is a
//   function of registered state and clear only. While out_valid is 1 and
//   out_ready is 0, out_sum/out_count/out_ovf hold stable.
//
//   A frame ends after COUNT products, or earlier on a product with in_last.
//   clear synchronously drops the partial frame and any pending result.
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   clear                 synchronous abort (priority over handshakes)
//   in_valid/in_ready     input handshake
//   in_data, in_last      product and end-of-frame marker
//   out_valid/out_ready   result handshake
//   out_sum               frame sum modulo 2^ACC_W
//   out_count             number of products in the frame
//   out_ovf               frame sum wrapped at least once
// ---------------------------------------------------------------------------
module product_accumulator #(
  parameter int IN_W  = 16,
  parameter int ACC_W = 24,
  parameter int COUNT = 4,
  parameter int CNT_W = $clog2(COUNT + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IN_W-1:0]  in_data,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_sum,
  output logic [CNT_W-1:0] out_count,
  output logic             out_ovf
);

  typedef enum logic {
    ST_ACC  = 1'b0,
    ST_DONE = 1'b1
  } state_t;

  state_t             state_q, state_d;
  logic [ACC_W-1:0]   acc_q, acc_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               ovf_q, ovf_d;
  logic               out_valid_q, out_valid_d;
  logic [ACC_W-1:0]   out_sum_q, out_sum_d;
  logic [CNT_W-1:0]   out_count_q, out_count_d;
  logic               out_ovf_q, out_ovf_d;

  // One extra bit so the carry out of the accumulator is visible.
  logic [ACC_W:0]     sum_ext;
  logic [CNT_W-1:0]   cnt_inc;
  logic               accept;
  logic               frame_end;
  logic               new_ovf;

  assign in_ready  = (state_q == ST_ACC) && !clear;
  assign out_valid = out_valid_q;
  assign out_sum   = out_sum_q;
  assign out_count = out_count_q;
  assign out_ovf   = out_ovf_q;

  always_comb begin
    sum_ext   = {1'b0, acc_q} + {{(ACC_W + 1 - IN_W){1'b0}}, in_data};
    cnt_inc   = cnt_q + CNT_W'(1);
    new_ovf   = ovf_q | sum_ext[ACC_W];
    accept    = in_valid && in_ready;
    frame_end = accept && ((cnt_inc == CNT_W'(COUNT)) || in_last);

    state_d     = state_q;
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    ovf_d       = ovf_q;
    out_valid_d = out_valid_q;
    out_sum_d   = out_sum_q;
    out_count_d = out_count_q;
    out_ovf_d   = out_ovf_q;

    if (clear) begin
      // Result registers are deliberately left alone.
      state_d     = ST_ACC;
      acc_d       = '0;
      cnt_d       = '0;
      ovf_d       = 1'b0;
      out_valid_d = 1'b0;
    end else if (state_q == ST_DONE) begin
      if (out_valid_q && out_ready) begin
        state_d     = ST_ACC;
        acc_d       = '0;
        cnt_d       = '0;
        ovf_d       = 1'b0;
        out_valid_d = 1'b0;
      end
    end else if (accept) begin
      acc_d = sum_ext[ACC_W-1:0];
      cnt_d = cnt_inc;
      ovf_d = new_ovf;
      if (frame_end) begin
        state_d     = ST_DONE;
        out_sum_d   = sum_ext[ACC_W-1:0];
        out_count_d = cnt_inc;
        out_ovf_d   = new_ovf;
        out_valid_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_ACC;
      acc_q       <= '0;
      cnt_q       <= '0;
      ovf_q       <= 1'b0;
      out_valid_q <= 1'b0;
      out_sum_q   <= '0;
      out_count_q <= '0;
      out_ovf_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      ovf_q       <= ovf_d;
      out_valid_q <= out_valid_d;
      out_sum_q   <= out_sum_d;
      out_count_q <= out_count_d;
      out_ovf_q   <= out_ovf_d;
    end
  end

endmodule

// File: tb/tb_product_accumulator.sv
module tb_product_accumulator;

  localparam int IN_W  = 16;
  localparam int ACC_W = 17;
  localparam int COUNT = 4;
  localparam int CNT_W = $clog2(COUNT + 1);
  localparam int EW    = 1 + CNT_W + ACC_W;
  localparam longint MOD = longint'(1) << ACC_W;

  // ---------------- clock / reset ----------------
  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             clear = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [IN_W-1:0]  in_data = '0;
  logic             in_last = 1'b0;
  logic             out_valid;
  logic             out_ready = 1'b1;
  logic [ACC_W-1:0] out_sum;
  logic [CNT_W-1:0] out_count;
  logic             out_ovf;

  always #5 clk = ~clk;

  product_accumulator #(
    .IN_W (IN_W),
    .ACC_W(ACC_W),
    .COUNT(COUNT),
    .CNT_W(CNT_W)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .clear    (clear),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .in_last  (in_last),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_sum  (out_sum),
    .out_count(out_count),
    .out_ovf  (out_ovf)
  );

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Results pending for the consumer, each {ovf, count, sum}.
  logic [EW-1:0] exp_q[$];
  longint        m_sum;
  int            m_cnt;
  longint        m_last_total;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      exp_q.delete();
      m_sum = 0;
      m_cnt = 0;
    end else if (clear) begin
      exp_q.delete();
      m_sum = 0;
      m_cnt = 0;
    end else if (exp_q.size() != 0) begin
      if (out_ready) void'(exp_q.pop_front());
    end else if (in_valid) begin
      m_sum += longint'(in_data);
      m_cnt++;
      if (m_cnt == COUNT || in_last) begin
        exp_q.push_back({(m_sum >= MOD), CNT_W'(m_cnt), ACC_W'(m_sum % MOD)});
        m_last_total = m_sum;
        m_sum = 0;
        m_cnt = 0;
      end
    end
  end

  // ---------------- scoreboard compare ----------------
  always @(negedge clk) begin
    if (rst_n && chk_en) begin
      chk("in_ready", {31'd0, in_ready}, {31'd0, (exp_q.size() == 0) && !clear});
      chk("out_valid", {31'd0, out_valid}, {31'd0, exp_q.size() != 0});
      if (exp_q.size() != 0) begin
        chk("out_sum", 32'(out_sum), 32'(exp_q[0][ACC_W-1:0]));
        chk("out_count", 32'(out_count), 32'(exp_q[0][ACC_W +: CNT_W]));
        chk("out_ovf", {31'd0, out_ovf}, {31'd0, exp_q[0][EW-1]});
      end
    end
  end

  // ---------------- driver tasks ----------------
  // All tasks start and end at posedge+1.
  task automatic send(input logic [IN_W-1:0] d, input logic last);
    bit ok;
    int n;
    in_valid = 1'b1;
    in_data  = d;
    in_last  = last;
    n = 0;
    ok = 1'b0;
    while (!ok && n < 50) begin
      @(negedge clk);
      ok = in_ready;
      @(posedge clk);
      #1;
      n++;
    end
    if (!ok) chk("send_timeout", 32'(n), 32'(0));
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic wait_result(input string name, input int e_sum, input int e_cnt,
                             input logic e_ovf, input int e_lat);
    int n;
    n = 0;
    while (!out_valid && n < 20) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk({name, "_latency"}, 32'(n), 32'(e_lat));
    chk({name, "_valid"}, {31'd0, out_valid}, 32'd1);
    chk({name, "_sum"}, 32'(out_sum), 32'(e_sum));
    chk({name, "_count"}, 32'(out_count), 32'(e_cnt));
    chk({name, "_ovf"}, {31'd0, out_ovf}, {31'd0, e_ovf});
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic send4(input int a, input int b, input int c, input int d);
    send(IN_W'(a), 1'b0);
    send(IN_W'(b), 1'b0);
    send(IN_W'(c), 1'b0);
    send(IN_W'(d), 1'b0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("rst_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_sum", 32'(out_sum), 32'd0);
    chk("rst_count", 32'(out_count), 32'd0);
    chk("rst_ovf", {31'd0, out_ovf}, 32'd0);
    chk("rst_ready", {31'd0, in_ready}, 32'd1);
    rst_n = 1'b1;
    chk_en = 1'b1;
    tick();

    // Full frame, back-to-back.
    send4(21, 49, 6, 10);
    wait_result("full", 86, 4, 1'b0, 0);
    chk("model_pin_full", 32'(m_last_total), 32'd86);
    chk("full_ready_busy", {31'd0, in_ready}, 32'd0);
    tick();
    chk("full_ready_back", {31'd0, in_ready}, 32'd1);
    chk("full_valid_drop", {31'd0, out_valid}, 32'd0);

    // Backpressure.
    out_ready = 1'b0;
    send4(7, 7, 7, 7);
    wait_result("bp", 28, 4, 1'b0, 0);
    in_valid = 1'b1;
    in_data  = 16'd99;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("bp_ready_low", {31'd0, in_ready}, 32'd0);
      chk("bp_sum_hold", 32'(out_sum), 32'd28);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    tick();
    chk("bp_handshake", {31'd0, out_valid}, 32'd0);
    tick();

    // Early end.
    send(16'd15, 1'b0);
    send(16'd25, 1'b1);
    wait_result("early", 40, 2, 1'b0, 0);
    tick();

    // Overflow, then a clean frame.
    send4(65535, 65535, 65535, 65535);
    wait_result("ovf", 131068, 4, 1'b1, 0);
    chk("model_pin_ovf", 32'(m_last_total % MOD), 32'd131068);
    tick();
    send4(1, 1, 1, 1);
    wait_result("post_ovf", 4, 4, 1'b0, 0);
    tick();

    // Asynchronous reset mid-frame.
    send(16'd40, 1'b0);
    send(16'd64, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_valid", {31'd0, out_valid}, 32'd0);
    chk("arst_sum", 32'(out_sum), 32'd0);
    chk("arst_count", 32'(out_count), 32'd0);
    chk("arst_ready", {31'd0, in_ready}, 32'd1);
    tick();
    rst_n = 1'b1;
    tick();
    send4(48, 40, 10, 15);
    wait_result("after_rst", 113, 4, 1'b0, 0);
    tick();

    // Clear while a result is pending.
    out_ready = 1'b0;
    send4(1, 2, 3, 4);
    wait_result("pre_clear", 10, 4, 1'b0, 0);
    clear    = 1'b1;
    in_valid = 1'b1;
    in_data  = 16'd50;
    #1;
    chk("clear_ready", {31'd0, in_ready}, 32'd0);
    tick();
    clear    = 1'b0;
    in_valid = 1'b0;
    chk("clear_valid", {31'd0, out_valid}, 32'd0);
    chk("clear_sum_kept", 32'(out_sum), 32'd10);
    out_ready = 1'b1;
    send4(2, 3, 4, 5);
    wait_result("after_clear", 14, 4, 1'b0, 0);
    tick();

    // Randomized traffic; the scoreboard checks every cycle.
    for (int i = 0; i < 400; i++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      in_data   = ($urandom_range(0, 3) == 0) ? IN_W'($urandom_range(60000, 65535))
                                              : IN_W'($urandom_range(0, 65535));
      in_last   = ($urandom_range(0, 4) == 0);
      out_ready = ($urandom_range(0, 9) < 7);
      clear     = ($urandom_range(0, 39) == 0);
      tick();
    end
    in_valid  = 1'b0;
    in_last   = 1'b0;
    clear     = 1'b0;
    out_ready = 1'b1;
    repeat (5) tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Hard stop if something stalls the stimulus.
  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
